instr_loader: RTL and testbench

//  Debug-unit stage directly upstream of instruction memory. Assembles UART-received bytes into
//  32-bit instructions and writes them sequentially into IM via wr_instruction/data_instruction.

---
 rtl/instr_loader_pkg.sv | 23 ++
 rtl/instr_loader_byte_assembler.sv | 32 +++
 rtl/instr_loader.sv | 145 ++++++++++++++
 tb/tb_instr_loader.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader, instruction memory and debug unit.
// Holds the loader FSM encoding, default memory geometry and the HALT terminator.
package instr_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWrite,
      StChk,
      StDone
   } loader_state_e;

   localparam int unsigned MemDepthDefault = 32;
   localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;

   // Never returns 0 so that a one-word memory still gets a legal address vector.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned ImAddrW = addr_width(MemDepthDefault);

endpackage

// File: rtl/instr_loader_byte_assembler.sv
// Collects bytes MSB-first into a 32-bit word; word_valid pulses combinationally
// in the cycle the 4th byte is accepted, with word already holding the full value.
module instr_loader_byte_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  rx_byte,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [23:0] shift_q;
   logic [1:0]  cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clear) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (accept) begin
         shift_q <= {shift_q[15:0], rx_byte};
         cnt_q   <= cnt_q + 2'd1;
      end
   end

   assign word       = {shift_q, rx_byte};
   assign word_valid = accept && (cnt_q == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Loads UART bytes as 32-bit words into instruction memory until HALT or memory full.
// Optional trailing checksum byte enabled with `define LOADER_CHKSUM_EN.
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int unsigned MEM_DEPTH = MemDepthDefault,
   parameter logic [31:0] HALT_WORD = HaltWordDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte,
   output logic        wr_instruction,
   output logic [31:0] data_instruction,
   output logic [31:0] wr_addr,
   output logic        load_busy,
   output logic        load_done,
   output logic        overflow,
   output logic        chk_err
);

   localparam int unsigned AddrW = addr_width(MEM_DEPTH);
   localparam logic [AddrW-1:0] LastAddr = AddrW'(MEM_DEPTH - 1);

   loader_state_e    state_q;
   logic [AddrW-1:0] addr_q;
   logic [AddrW-1:0] wr_addr_q;
   logic [31:0]      word;
   logic             word_valid;
   logic             accept;
   logic             start;
   logic             final_word;

   assign start      = load_start && ((state_q == StIdle) || (state_q == StDone));
   assign final_word = (data_instruction == HALT_WORD) || (addr_q == LastAddr);
   // A byte arriving during WRITE opens the next word unless this word ends the load.
   assign accept     = rx_valid &&
                       ((state_q == StRecv) || ((state_q == StWrite) && !final_word));
   assign wr_addr    = {{(32 - AddrW){1'b0}}, wr_addr_q};

   instr_loader_byte_assembler u_byte_assembler (
      .clk        (clk),
      .rst        (rst),
      .clear      (start),
      .accept     (accept),
      .rx_byte    (rx_byte),
      .word       (word),
      .word_valid (word_valid)
   );

`ifdef LOADER_CHKSUM_EN
   logic [7:0] chksum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chksum_q <= '0;
      end else if (start) begin
         chksum_q <= '0;
      end else if (accept) begin
         chksum_q <= chksum_q ^ rx_byte;
      end
   end
`else
   assign chk_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= StIdle;
         addr_q           <= '0;
         wr_addr_q        <= '0;
         wr_instruction   <= 1'b0;
         data_instruction <= '0;
         load_busy        <= 1'b0;
         load_done        <= 1'b0;
         overflow         <= 1'b0;
`ifdef LOADER_CHKSUM_EN
         chk_err          <= 1'b0;
`endif
      end else begin
         wr_instruction <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q   <= StRecv;
                  addr_q    <= '0;
                  load_busy <= 1'b1;
                  load_done <= 1'b0;
                  overflow  <= 1'b0;
`ifdef LOADER_CHKSUM_EN
                  chk_err   <= 1'b0;
`endif
               end
            end
            StRecv: begin
               if (word_valid) begin
                  state_q          <= StWrite;
                  wr_instruction   <= 1'b1;
                  data_instruction <= word;
                  wr_addr_q        <= addr_q;
               end
            end
            StWrite: begin
               if (data_instruction == HALT_WORD) begin
`ifdef LOADER_CHKSUM_EN
                  if (rx_valid) begin
                     chk_err   <= (rx_byte != chksum_q);
                     state_q   <= StDone;
                     load_busy <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     state_q <= StChk;
                  end
`else
                  state_q   <= StDone;
                  load_busy <= 1'b0;
                  load_done <= 1'b1;
`endif
               end else if (addr_q == LastAddr) begin
                  state_q   <= StDone;
                  load_busy <= 1'b0;
                  load_done <= 1'b1;
                  overflow  <= 1'b1;
               end else begin
                  addr_q  <= addr_q + 1'b1;
                  state_q <= StRecv;
               end
            end
`ifdef LOADER_CHKSUM_EN
            StChk: begin
               if (rx_valid) begin
                  chk_err   <= (rx_byte != chksum_q);
                  state_q   <= StDone;
                  load_busy <= 1'b0;
                  load_done <= 1'b1;
               end
            end
`endif
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed sequence with randomized words,
// checked against a word-list model built from the byte stream.
module tb_instr_loader;

   localparam int unsigned Depth = 32;
   localparam logic [31:0] Halt = 32'hFFFF_FFFF;

   typedef logic [7:0] byte_q_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        wr_instruction;
   logic [31:0] data_instruction;
   logic [31:0] wr_addr;
   logic        load_busy;
   logic        load_done;
   logic        overflow;
   logic        chk_err;

   int checks = 0;
   int failures = 0;

   logic [31:0] cap_addr[$];
   logic [31:0] cap_data[$];
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic        exp_ovf;
   logic        exp_chk;

   instr_loader #(
      .MEM_DEPTH (Depth),
      .HALT_WORD (Halt)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .load_start       (load_start),
      .rx_valid         (rx_valid),
      .rx_byte          (rx_byte),
      .wr_instruction   (wr_instruction),
      .data_instruction (data_instruction),
      .wr_addr          (wr_addr),
      .load_busy        (load_busy),
      .load_done        (load_done),
      .overflow         (overflow),
      .chk_err          (chk_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_instruction) begin
         cap_addr.push_back(wr_addr);
         cap_data.push_back(data_instruction);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      cycle();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid = 1'b1;
      rx_byte  = b;
      cycle();
      rx_valid = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic send_stream(input byte_q_t s, input int max_gap);
      foreach (s[i]) send_byte(s[i], $urandom_range(0, max_gap));
   endtask

   task automatic push_word(inout byte_q_t s, input logic [31:0] w);
      s.push_back(w[31:24]);
      s.push_back(w[23:16]);
      s.push_back(w[15:8]);
      s.push_back(w[7:0]);
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == Halt) w = 32'h0;
      return w;
   endfunction

   // Expected writes: consecutive 4-byte words at addresses 0,1,..; stop after HALT or Depth words.
   task automatic build_model(input byte_q_t s);
      logic [31:0] w;
      logic [7:0]  x;
      exp_addr.delete();
      exp_data.delete();
      exp_ovf = 1'b0;
      exp_chk = 1'b0;
      x = 8'h00;
      for (int i = 0; i + 3 < s.size(); i += 4) begin
         w = {s[i], s[i+1], s[i+2], s[i+3]};
         x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
         exp_addr.push_back(32'(exp_data.size()));
         exp_data.push_back(w);
         if (w == Halt) begin
`ifdef LOADER_CHKSUM_EN
            if (i + 4 < s.size()) exp_chk = (s[i+4] != x);
`endif
            break;
         end
         if (exp_data.size() == Depth) begin
            exp_ovf = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!load_done && n < 60) begin
         cycle();
         n++;
      end
      check({tag, "_done"}, {31'b0, load_done}, 32'd1);
   endtask

   task automatic compare(input string tag);
      int n;
      check({tag, "_nwr"}, 32'(cap_data.size()), 32'(exp_data.size()));
      n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_addr%0d", tag, i), cap_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), cap_data[i], exp_data[i]);
      end
      check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
      check({tag, "_busy"}, {31'b0, load_busy}, 32'd0);
      check({tag, "_chk"}, {31'b0, chk_err}, {31'b0, exp_chk});
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr"}, {31'b0, wr_instruction}, 32'd0);
      check({tag, "_data"}, data_instruction, 32'd0);
      check({tag, "_addr"}, wr_addr, 32'd0);
      check({tag, "_flags"}, {28'b0, load_busy, load_done, overflow, chk_err}, 32'd0);
   endtask

   task automatic full_load(input string tag, input byte_q_t s, input int max_gap);
      cap_addr.delete();
      cap_data.delete();
      build_model(s);
      start_load();
      send_stream(s, max_gap);
      wait_done(tag);
      repeat (2) cycle();
      compare(tag);
   endtask

   initial begin
      byte_q_t s;

      // Power-on reset, then a reset pulse mid-word.
      #2;
      check_all_zero("por");
      cycle();
      rst = 1'b1;
      cycle();
      start_load();
      send_byte(8'hAB, 0);
      send_byte(8'hCD, 1);
      cap_addr.delete();
      cap_data.delete();
      #3 rst = 1'b0;
      #1 check_all_zero("midrst");
      cycle();
      rst = 1'b1;
      cycle();
      check(  "midrst_nowr", 32'(cap_data.size()), 32'd0);
      s = {};
      push_word(s, rand_word());
      push_word(s, Halt);
      s.push_back(8'($urandom_range(0, 255)));
      full_load("fresh", s, 2);

      // Fixed two-word load with latency check on the first word.
      cap_addr.delete();
      cap_data.delete();
      s = {8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h24};
      build_model(s);
      start_load();
      check("busy_after_start", {31'b0, load_busy}, 32'd1);
      send_byte(8'h20, 1);
      send_byte(8'h01, 0);
      send_byte(8'h00, 2);
      check("no_early_wr", {31'b0, wr_instruction}, 32'd0);
      send_byte(8'h05, 0);
      check("lat_wr", {31'b0, wr_instruction}, 32'd1);
      check("lat_data", data_instruction, 32'h2001_0005);
      check("lat_addr", wr_addr, 32'd0);
      send_stream(s[4:8], 0);
      wait_done("fixed");
      repeat (2) cycle();
      compare("fixed");

      // Fill the memory without HALT; trailing bytes must be ignored.
      s = {};
      for (int i = 0; i < Depth; i++) push_word(s, rand_word());
      for (int i = 0; i < 6; i++) s.push_back(8'hFF);
      full_load("ovf", s, 1);

      // load_start in DONE clears flags; load_start during RECV is ignored.
      cap_addr.delete();
      cap_data.delete();
      s = {};
      push_word(s, rand_word());
      push_word(s, Halt);
      s.push_back(8'($urandom_range(0, 255)));
      build_model(s);
      start_load();
      check("restart_done", {31'b0, load_done}, 32'd0);
      check("restart_ovf", {31'b0, overflow}, 32'd0);
      send_byte(s[0], 0);
      send_byte(s[1], 0);
      start_load();
      send_stream(s[2:$], 1);
      wait_done("ignstart");
      repeat (2) cycle();
      compare("ignstart");

      // Back-to-back bytes: the first byte of each word lands in the WRITE cycle.
      s = {};
      for (int i = 0; i < 7; i++) push_word(s, rand_word());
      push_word(s, Halt);
      s.push_back(8'($urandom_range(0, 255)));
      full_load("b2b", s, 0);

      // Random gaps, HALT landing on the last address.
      s = {};
      for (int i = 0; i < Depth - 1; i++) push_word(s, rand_word());
      push_word(s, Halt);
      s.push_back(8'($urandom_range(0, 255)));
      full_load("lasthalt", s, 3);

`ifdef LOADER_CHKSUM_EN
      s = {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
      full_load("chk_ok", s, 1);
      check("chk_ok_val", {31'b0, chk_err}, 32'd0);
      s = {8'h00, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00};
      full_load("chk_bad", s, 1);
      check("chk_bad_val", {31'b0, chk_err}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
